// File: rtl/i2c_bridge_pkg.sv
// Shared definitions for the AXI-to-I2C bridge: FSM encoding and default byte widths.
package i2c_bridge_pkg;

  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 8;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WAIT_BUSY = 2'd1,
    S_WAIT_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/i2c_cmd_fifo.sv
// Generic synchronous circular FIFO with flush, explicit level counter and head-of-queue read.
module i2c_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       res_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  input  logic                       flush,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       drop
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  // A pop frees a slot in the same cycle, so a push into a full queue is still taken.
  assign do_pop  = pop && !empty && !flush;
  assign do_push = push && !flush && (!full || do_pop);
  assign drop    = push && !flush && !do_push;

  always_ff @(posedge clk) begin
    if (!res_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];
  assign full  = (level == LVL_W'(DEPTH));
  assign empty = (level == '0);

endmodule

// File: rtl/i2c_cmd_queue.sv
// Command queue feeding the I2C master: buffers pushes, issues one command at a time,
// and watches the master's busy handshake with a timeout.
module i2c_cmd_queue
  import i2c_bridge_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int BUSY_TIMEOUT = 16
) (
  input  logic                   clk,
  input  logic                   res_n,
  input  logic                   push,
  input  logic [ADDR_W-1:0]      push_addr,
  input  logic [DATA_W-1:0]      push_data,
  input  logic                   flush,
  input  logic                   clr_err,
  input  logic                   i2c_busy,
  output logic [ADDR_W-1:0]      cmd_addr,
  output logic [DATA_W-1:0]      cmd_data,
  output logic                   new_cmd,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level,
  output logic                   active,
  output logic                   overflow,
  output logic                   timeout_err
);

  localparam int CNT_W = $clog2(BUSY_TIMEOUT) + 1;

  state_t                   state;
  state_t                   state_next;
  logic [CNT_W-1:0]         cnt;
  logic                     issue;
  logic                     tmo_hit;
  logic                     drop;
  logic [ADDR_W+DATA_W-1:0] head;

  i2c_cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ADDR_W + DATA_W)
  ) u_fifo (
    .clk   (clk),
    .res_n (res_n),
    .push  (push),
    .wdata ({push_addr, push_data}),
    .pop   (issue),
    .flush (flush),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .level (level),
    .drop  (drop)
  );

  // A flush in the same cycle suppresses the issue so the head entry is discarded, not sent.
  always_comb begin
    state_next = state;
    issue      = 1'b0;
    tmo_hit    = 1'b0;
    case (state)
      S_IDLE: begin
        if (!empty && !i2c_busy && !flush) begin
          issue      = 1'b1;
          state_next = S_WAIT_BUSY;
        end
      end
      S_WAIT_BUSY: begin
        if (i2c_busy) begin
          state_next = S_WAIT_DONE;
        end else if (cnt == CNT_W'(BUSY_TIMEOUT - 1)) begin
          tmo_hit    = 1'b1;
          state_next = S_IDLE;
        end
      end
      S_WAIT_DONE: begin
        if (!i2c_busy) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!res_n) state <= S_IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (!res_n) begin
      cnt         <= '0;
      new_cmd     <= 1'b0;
      cmd_addr    <= '0;
      cmd_data    <= '0;
      overflow    <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      new_cmd <= issue;
      if (issue) begin
        cmd_addr <= head[ADDR_W+DATA_W-1 -: ADDR_W];
        cmd_data <= head[DATA_W-1:0];
        cnt      <= '0;
      end else if (state == S_WAIT_BUSY && !i2c_busy) begin
        cnt <= cnt + CNT_W'(1);
      end
      // Sticky flags: a new error in the same cycle beats the software clear.
      if (drop)         overflow <= 1'b1;
      else if (clr_err) overflow <= 1'b0;
      if (tmo_hit)      timeout_err <= 1'b1;
      else if (clr_err) timeout_err <= 1'b0;
    end
  end

  assign active = (state != S_IDLE);

endmodule

// File: tb/tb_i2c_cmd_queue.sv
// Directed self-checking bench for i2c_cmd_queue with a simple I2C master busy model.
module tb_i2c_cmd_queue;

  localparam int DEPTH = 4;
  localparam int BT    = 16;

  logic       clk = 1'b0;
  logic       res_n;
  logic       push;
  logic [7:0] push_addr;
  logic [7:0] push_data;
  logic       flush;
  logic       clr_err;
  logic       i2c_busy;
  logic [7:0] cmd_addr;
  logic [7:0] cmd_data;
  logic       new_cmd;
  logic       full;
  logic       empty;
  logic [2:0] level;
  logic       active;
  logic       overflow;
  logic       timeout_err;

  int total = 0;
  int bad   = 0;

  bit         auto_busy;
  int         busy_len;
  int         busy_cnt;
  int         pulses;
  int         viol;
  bit         prev_new;
  logic [7:0] pa [16];
  logic [7:0] pd [16];
  int         n;

  i2c_cmd_queue #(
    .DEPTH        (DEPTH),
    .ADDR_W       (8),
    .DATA_W       (8),
    .BUSY_TIMEOUT (BT)
  ) dut (
    .clk         (clk),
    .res_n       (res_n),
    .push        (push),
    .push_addr   (push_addr),
    .push_data   (push_data),
    .flush       (flush),
    .clr_err     (clr_err),
    .i2c_busy    (i2c_busy),
    .cmd_addr    (cmd_addr),
    .cmd_data    (cmd_data),
    .new_cmd     (new_cmd),
    .full        (full),
    .empty       (empty),
    .level       (level),
    .active      (active),
    .overflow    (overflow),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // One clock: sample just after the edge, log pulses, then advance the busy model.
  task automatic tick();
    @(posedge clk);
    #1;
    if (new_cmd) begin
      if (pulses < 16) begin
        pa[pulses] = cmd_addr;
        pd[pulses] = cmd_data;
      end
      pulses++;
      if (i2c_busy) viol++;
      if (prev_new) viol++;
    end
    prev_new = new_cmd;
    if (auto_busy) begin
      if (busy_cnt > 0) begin
        busy_cnt--;
        if (busy_cnt == 0) i2c_busy = 1'b0;
      end else if (new_cmd) begin
        i2c_busy = 1'b1;
        busy_cnt = busy_len;
      end
    end
  endtask

  task automatic applyStimulus(input logic p, input logic [7:0] a, input logic [7:0] d,
                               input logic f, input logic c);
    push      = p;
    push_addr = a;
    push_data = d;
    flush     = f;
    clr_err   = c;
    tick();
    push    = 1'b0;
    flush   = 1'b0;
    clr_err = 1'b0;
  endtask

  task automatic waitIdle(input int budget, output int cycles);
    cycles = 0;
    while (active && cycles < budget) begin
      tick();
      cycles++;
    end
    checkOutput("wait_idle_bound", 32'(active), 32'd0);
  endtask

  initial begin
    res_n = 1'b0; push = 1'b0; push_addr = '0; push_data = '0;
    flush = 1'b0; clr_err = 1'b0; i2c_busy = 1'b0;
    auto_busy = 1'b0; busy_len = 0; busy_cnt = 0; pulses = 0; viol = 0; prev_new = 1'b0;

    tick();
    tick();
    checkOutput("rst_new_cmd", 32'(new_cmd), 32'd0);
    checkOutput("rst_empty", 32'(empty), 32'd1);
    checkOutput("rst_full", 32'(full), 32'd0);
    checkOutput("rst_level", 32'(level), 32'd0);
    checkOutput("rst_active", 32'(active), 32'd0);
    checkOutput("rst_flags", 32'({overflow, timeout_err}), 32'd0);
    checkOutput("rst_cmd", 32'({cmd_addr, cmd_data}), 32'd0);
    res_n = 1'b1;

    // Single command with a 20-cycle busy response.
    auto_busy = 1'b1; busy_len = 20; busy_cnt = 0; pulses = 0;
    applyStimulus(1'b1, 8'h50, 8'hA5, 1'b0, 1'b0);
    checkOutput("t1_level_after_push", 32'(level), 32'd1);
    checkOutput("t1_no_early_pulse", 32'(new_cmd), 32'd0);
    tick();
    checkOutput("t1_pulse", 32'(new_cmd), 32'd1);
    checkOutput("t1_addr", 32'(cmd_addr), 32'h50);
    checkOutput("t1_data", 32'(cmd_data), 32'hA5);
    checkOutput("t1_active", 32'(active), 32'd1);
    checkOutput("t1_level_popped", 32'(level), 32'd0);
    tick();
    checkOutput("t1_pulse_width", 32'(new_cmd), 32'd0);
    checkOutput("t1_active_hold", 32'(active), 32'd1);
    waitIdle(100, n);
    checkOutput("t1_active_cycles", 32'(n), 32'd20);
    checkOutput("t1_pulse_count", 32'(pulses), 32'd1);

    // Fill while the master reports busy externally, overflow, clear, then push-with-pop.
    auto_busy = 1'b0; i2c_busy = 1'b1; pulses = 0;
    for (int i = 0; i < 4; i++)
      applyStimulus(1'b1, 8'h10 + 8'(i), 8'h01 + 8'(i), 1'b0, 1'b0);
    checkOutput("t2_full", 32'(full), 32'd1);
    checkOutput("t2_level4", 32'(level), 32'd4);
    checkOutput("t2_blocked_idle", 32'(active), 32'd0);
    applyStimulus(1'b1, 8'hEE, 8'hEE, 1'b0, 1'b0);
    checkOutput("t3_overflow_set", 32'(overflow), 32'd1);
    checkOutput("t3_level_kept", 32'(level), 32'd4);
    applyStimulus(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
    checkOutput("t3_overflow_clr", 32'(overflow), 32'd0);
    i2c_busy = 1'b0; auto_busy = 1'b1; busy_len = 10; busy_cnt = 0;
    applyStimulus(1'b1, 8'h14, 8'h05, 1'b0, 1'b0);
    checkOutput("t3_issue_pulse", 32'(new_cmd), 32'd1);
    checkOutput("t3_issue_addr", 32'(cmd_addr), 32'h10);
    checkOutput("t3_level_same", 32'(level), 32'd4);
    checkOutput("t3_no_overflow", 32'(overflow), 32'd0);
    n = 0;
    while ((pulses < 5 || active) && n < 300) begin
      tick();
      n++;
    end
    checkOutput("t2_pulse_count", 32'(pulses), 32'd5);
    for (int i = 0; i < 5; i++) begin
      checkOutput($sformatf("t2_addr%0d", i), 32'(pa[i]), 32'h10 + 32'(i));
      checkOutput($sformatf("t2_data%0d", i), 32'(pd[i]), 32'h01 + 32'(i));
    end
    checkOutput("t2_handshake_viol", 32'(viol), 32'd0);
    checkOutput("t2_drained", 32'(empty), 32'd1);

    // Master never raises busy: timeout, then the next entry is issued.
    auto_busy = 1'b0; i2c_busy = 1'b0; pulses = 0;
    applyStimulus(1'b1, 8'h20, 8'h21, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h22, 8'h23, 1'b0, 1'b0);
    checkOutput("t4_pulse", 32'(new_cmd), 32'd1);
    checkOutput("t4_addr", 32'(cmd_addr), 32'h20);
    n = 0;
    while (!timeout_err && n < 50) begin
      tick();
      n++;
    end
    checkOutput("t4_timeout_cycles", 32'(n), 32'(BT));
    checkOutput("t4_back_idle", 32'(active), 32'd0);
    tick();
    checkOutput("t4_next_pulse", 32'(new_cmd), 32'd1);
    checkOutput("t4_next_cmd", 32'({cmd_addr, cmd_data}), 32'h2223);
    waitIdle(50, n);
    checkOutput("t4_pulse_count", 32'(pulses), 32'd2);
    applyStimulus(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
    checkOutput("t4_timeout_clr", 32'(timeout_err), 32'd0);

    // Flush while a command is in flight.
    auto_busy = 1'b1; busy_len = 10; busy_cnt = 0; i2c_busy = 1'b0; pulses = 0;
    applyStimulus(1'b1, 8'h30, 8'hA0, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h31, 8'hA1, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h32, 8'hA2, 1'b0, 1'b0);
    checkOutput("t5_level2", 32'(level), 32'd2);
    applyStimulus(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
    checkOutput("t5_flush_level", 32'(level), 32'd0);
    checkOutput("t5_inflight", 32'(active), 32'd1);
    checkOutput("t5_cmd_kept", 32'(cmd_addr), 32'h30);
    waitIdle(100, n);
    repeat (10) tick();
    checkOutput("t5_single_pulse", 32'(pulses), 32'd1);
    auto_busy = 1'b0; i2c_busy = 1'b1;
    for (int i = 0; i < 4; i++)
      applyStimulus(1'b1, 8'h60 + 8'(i), 8'h70 + 8'(i), 1'b0, 1'b0);
    checkOutput("t5_full_again", 32'(full), 32'd1);
    applyStimulus(1'b1, 8'h77, 8'h77, 1'b1, 1'b0);
    checkOutput("t5_flushpush_level", 32'(level), 32'd0);
    checkOutput("t5_flushpush_ovf", 32'(overflow), 32'd0);
    checkOutput("t5_flushpush_empty", 32'(empty), 32'd1);
    i2c_busy = 1'b0;
    repeat (5) tick();
    checkOutput("t5_no_more_pulses", 32'(pulses), 32'd1);

    // Reset during WAIT_DONE with two entries still queued.
    pulses = 0;
    applyStimulus(1'b1, 8'h40, 8'hB0, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h41, 8'hB1, 1'b0, 1'b0);
    checkOutput("t6_issue", 32'(cmd_addr), 32'h40);
    i2c_busy = 1'b1;
    applyStimulus(1'b1, 8'h42, 8'hB2, 1'b0, 1'b0);
    checkOutput("t6_wait_done", 32'(active), 32'd1);
    checkOutput("t6_level2", 32'(level), 32'd2);
    res_n = 1'b0;
    tick();
    checkOutput("t6_rst_cmd", 32'({cmd_addr, cmd_data}), 32'd0);
    checkOutput("t6_rst_level", 32'(level), 32'd0);
    checkOutput("t6_rst_empty", 32'(empty), 32'd1);
    checkOutput("t6_rst_misc", 32'({new_cmd, full, active, overflow, timeout_err}), 32'd0);
    res_n = 1'b1; i2c_busy = 1'b0; pulses = 0;
    repeat (5) tick();
    checkOutput("t6_no_pulse_after_rst", 32'(pulses), 32'd0);
    applyStimulus(1'b1, 8'h43, 8'hB3, 1'b0, 1'b0);
    tick();
    checkOutput("t6_new_pulse", 32'(new_cmd), 32'd1);
    checkOutput("t6_new_cmd", 32'({cmd_addr, cmd_data}), 32'h43B3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
